// File: rtl/synram_nrnw_clr.sv
// synram_nrnw_clr: multi-read, dual-write register-file RAM with a sequential clear engine.
// NUM_READ registered read ports come from NUM_READ/2 replicated 2r2w banks.
// All banks take the same writes, so they always hold the same contents.
// Write port 2 wins a same-address collision. Out-of-range writes are dropped.
// Out-of-range reads return 0.
// Reset or clear_i starts a sweep that zeroes one entry per cycle.
// While the sweep runs, user writes are blocked and all read data is 0.
// Optional macro SYNRAM_BYPASS_EN: reads are write-first, forwarding same-edge write data.
// Without it, reads are read-first.
//
// state  | meaning
// IDLE   | normal read/write traffic, waiting for clear_i
// CLEAR  | sweeping clr_ptr over every entry, writing zero; busy_o high
module synram_nrnw_clr #(
    parameter int BRAM_ADDR_WIDTH = 5,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int DATA_DEPTH      = 32,
    parameter int NUM_READ        = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 clear_i,
    output logic                                 busy_o,
    input  logic [NUM_READ*BRAM_ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_READ*BRAM_DATA_WIDTH-1:0]  rdata_o,
    input  logic [BRAM_ADDR_WIDTH-1:0]           waddr1_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]           waddr2_i,
    input  logic [BRAM_DATA_WIDTH-1:0]           wdata1_i,
    input  logic [BRAM_DATA_WIDTH-1:0]           wdata2_i,
    input  logic                                 we1_i,
    input  logic                                 we2_i
);

    localparam int AW        = BRAM_ADDR_WIDTH;
    localparam int DW        = BRAM_DATA_WIDTH;
    localparam int NUM_BANKS = NUM_READ / 2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_ptr;
    logic            w_idle;
    logic            w_we1_ok;
    logic            w_we2_ok;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < 32'(DATA_DEPTH);
    endfunction

    assign busy_o   = (r_state == ST_CLEAR);
    assign w_idle   = (r_state == ST_IDLE);
    assign w_we1_ok = w_idle && we1_i && in_range(waddr1_i);
    assign w_we2_ok = w_idle && we2_i && in_range(waddr2_i);

    // Clear-engine FSM: sweep clr_ptr from 0 to DATA_DEPTH-1, then return to IDLE
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_i) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state   <= ST_IDLE;
                        r_clr_ptr <= '0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DW-1:0] r_mem [DATA_DEPTH];

        // Bank storage: sweep zeroes while clearing, otherwise port 1 then port 2 (port 2 wins)
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                if (r_state == ST_CLEAR) begin
                    r_mem[r_clr_ptr] <= '0;
                end else begin
                    if (w_we1_ok) r_mem[waddr1_i] <= wdata1_i;
                    if (w_we2_ok) r_mem[waddr2_i] <= wdata2_i;
                end
            end
        end

        for (genvar p = 0; p < 2; p++) begin : g_port
            localparam int K = 2 * b + p;
            logic [AW-1:0] w_raddr;
            logic [DW-1:0] w_next;
            logic [DW-1:0] r_rdata;

            assign w_raddr = raddr_i[K*AW +: AW];

`ifdef SYNRAM_BYPASS_EN
            // Write-first: forward a same-edge write to this address, port 2 first
            always_comb begin
                w_next = in_range(w_raddr) ? r_mem[w_raddr] : '0;
                if (w_we2_ok && (waddr2_i == w_raddr)) begin
                    w_next = wdata2_i;
                end else if (w_we1_ok && (waddr1_i == w_raddr)) begin
                    w_next = wdata1_i;
                end
            end
`else
            assign w_next = in_range(w_raddr) ? r_mem[w_raddr] : '0;
`endif

            // Registered read port; forced to zero during reset and the clear sweep
            always_ff @(posedge clk_i) begin
                if (reset_i || (r_state == ST_CLEAR)) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_next;
                end
            end

            assign rdata_o[K*DW +: DW] = r_rdata;
        end
    end

endmodule

// File: doc/synram_nrnw_clr.md
Name: synram_nrnw_clr

Overview:
- Parametrised successor to the 4-read/2-write register-file RAM used in the dispatch stage.
- NUM_READ registered read ports are built from NUM_READ/2 replicated 2r2w banks that share two write ports.
- Adds deterministic write-collision priority, range checking, and a sequential clear engine. The clear engine zeroes every entry after reset or on request.
- Used as the rename/physical register storage backing the dispatch logic.

Parameters:
- BRAM_ADDR_WIDTH, 5, address width of every port.
- BRAM_DATA_WIDTH, 32, entry width.
- DATA_DEPTH, 32, number of entries; must be ≤ 2^BRAM_ADDR_WIDTH.
- NUM_READ, 4, number of read ports; must be even and ≥ 2; banks = NUM_READ/2.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- clear_i  in  1  request a full clear of memory contents.
- busy_o  out  1  high while the clear engine runs.
- raddr_i  in  NUM_READ*BRAM_ADDR_WIDTH  read addresses; port k is slice [k*AW +: AW].
- rdata_o  out  NUM_READ*BRAM_DATA_WIDTH  registered read data; port k is slice [k*DW +: DW].
- waddr1_i  in  BRAM_ADDR_WIDTH  write port 1 address.
- waddr2_i  in  BRAM_ADDR_WIDTH  write port 2 address.
- wdata1_i  in  BRAM_DATA_WIDTH  write port 1 data.
- wdata2_i  in  BRAM_DATA_WIDTH  write port 2 data.
- we1_i  in  1  write port 1 enable.
- we2_i  in  1  write port 2 enable.

Behaviour:
- Reset:
  - reset_i=1 forces state CLEAR, clr_ptr=0, busy_o=1, all rdata_o=0.
  - Reset asserted mid-clear restarts the sweep at entry 0.
- FSM, two states:
  - IDLE: clear_i=1 -> CLEAR next cycle with clr_ptr=0. Otherwise stay.
  - CLEAR: each cycle writes 0 to mem[clr_ptr] in every bank, then clr_ptr+1.
  - CLEAR exits when clr_ptr==DATA_DEPTH-1 is written; the next state is IDLE.
  - The sweep takes exactly DATA_DEPTH cycles after reset deasserts. busy_o falls on the cycle the FSM reaches IDLE.
  - clear_i is ignored while in CLEAR.
- busy_o = (state==CLEAR).
- While busy_o=1:
  - we1_i/we2_i are ignored; no user write reaches memory.
  - rdata_o registers load 0.
- Read (IDLE):
  - rdata_o[k] <= mem[raddr_k] on each edge; latency 1 cycle.
  - All ports are independent; any number of ports may share an address.
  - Address ≥ DATA_DEPTH returns 0.
- Write (IDLE):
  - A write commits at the edge where weN_i=1. Every bank receives an identical write, so all banks stay coherent.
  - Address ≥ DATA_DEPTH: the write is dropped.
  - we1_i and we2_i both high to the same address: wdata2_i is stored (port 2 wins).
- Read-during-write, same address and same edge: rdata_o returns the OLD contents (read-first), unless SYNRAM_BYPASS_EN is defined.
- clear_i=1 and a write in the same IDLE cycle: the write commits, then the sweep zeroes it.
- No reset of memory array except via the clear sweep. rdata_o are the only reset flops besides the FSM and clr_ptr.

Optional Feature:
- Macro: SYNRAM_BYPASS_EN.
- Defined: write-first forwarding.
  - If port k's raddr equals an enabled, in-range write address on the same edge, rdata_o[k] loads that write's data.
  - Port 2 takes precedence when both writes match.
  - No forwarding while busy_o=1.
- Undefined: read-first behaviour; no comparators are generated.

Test Plan:
- Reset then idle:
  - Pulse reset_i 1 cycle, DATA_DEPTH=32 -> busy_o=1 for exactly 32 cycles then 0.
  - Afterwards, reads of addresses 0..31 on all 4 ports return 0.
- Basic write/read:
  - we1_i=1 waddr1_i=3 wdata1_i=0xDEADBEEF; next cycle raddr port 2 = 3 -> rdata_o port 2 = 0xDEADBEEF one cycle later.
  - The same value is seen on ports 0,1,3, confirming bank coherence.
- Collision:
  - we1_i=we2_i=1, both addresses 7, wdata1_i=0x11, wdata2_i=0x22 -> a subsequent read of 7 returns 0x22.
- Read-during-write:
  - mem[5]=0xAA; write 0xBB to 5 while reading 5 -> 0xAA without the macro, 0xBB with SYNRAM_BYPASS_EN.
  - The next read returns 0xBB in both builds.
- Clear during traffic:
  - Fill entries 0..31 with nonzero data; assert clear_i for 1 cycle with we1_i=1 waddr1_i=9.
  - busy_o=1 for 32 cycles; writes issued during busy are discarded.
  - All entries read 0 afterwards.
- Reset mid-clear and range:
  - Assert reset_i at clr_ptr=10 -> sweep restarts, busy_o lasts a further 32 cycles.
  - With DATA_DEPTH=20, a write to address 25 is dropped and a read of 25 returns 0.
